shake_squeeze_reader: RTL and testbench
=======================================

// Module: shake_squeeze_reader
// PURPOSE
//  Squeeze-side reader for the Keccak permutation: captures the rate portion of the
//  1600-bit state when the permutation reports valid, streams it out word by word
//  over a valid/ready handshake, and requests further permutations until len_words
//  words are delivered. Feeds SHAKE output (e.g. Kyber matrix/noise sampling) downstream.
// PARAMETERS
//  RATE_BITS  1344  squeeze rate in bits (1344 = SHAKE128, 1088 = SHAKE256); multiple of WORD_W
//  WORD_W     64    output word width; one Keccak lane at the default
//  LEN_W      16    width of len_words / remaining-word counter
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         synchronous, active-high reset
//  start      in   1         1-cycle pulse: begin squeezing len_words words (IDLE only)
//  len_words  in   LEN_W     number of output words; sampled on start
//  perm_valid in   1         permutation state_in valid
//  state_in   in   1600      permutation state; lane i = x+5y at state_in[i*64 +: 64]
//  perm_next  out  1         1-cycle pulse: permutation runs f again on its held state
//  out_data   out  WORD_W    output word; word k = buffered state_in[k*WORD_W +: WORD_W]
//  out_valid  out  1         out_data valid
//  out_ready  in   1         consumer accepts out_data when out_valid & out_ready
//  busy       out  1         high in any state other than IDLE
//  done       out  1         1-cycle pulse after last word accepted
// BEHAVIOUR
//  - Reset (sync, any state, incl. mid-stream): state=IDLE; perm_next, out_valid, busy,
//    done = 0; out_data = 0; word index and remaining counter = 0.
//  - WORDS = RATE_BITS/WORD_W (21 at default); word index width $clog2(WORDS).
//  - IDLE: start & len_words==0 -> done pulses next cycle, stay IDLE, no perm_next.
//    start & len_words>0 -> remaining=len_words, WAIT. start outside IDLE is ignored.
//  - WAIT: perm_valid high -> register state_in[RATE_BITS-1:0] into rate buffer,
//    index=0, go STREAM; out_valid high the following cycle with word 0.
//    perm_valid outside WAIT is ignored; capacity bits are never stored.
//  - STREAM: out_data = buffer word[index]; out_data/out_valid held stable until
//    accepted. On accept: remaining-=1, index+=1.
//      remaining becomes 0 -> out_valid low, done pulse next cycle, IDLE (no perm_next,
//      also when last word is also last of the block).
//      index wraps past WORDS-1 with remaining>0 -> out_valid low, perm_next pulse
//      next cycle, go WAIT; capture next perm_valid as new block.
//  - Throughput: 1 word/cycle with out_ready held high; no bubble inside a block.
//  - out_ready while out_valid low has no effect. Data bytes are lane little-endian,
//    exactly as held in state_in; no reordering.
// STRUCTURE
//  - keccak_pkg: STATE_W=1600, LANE_W=64, SHAKE128_RATE=1344, SHAKE256_RATE=1088,
//    typedef enum {IDLE, WAIT, STREAM} squeeze_state_t.
//  - No sub-module: single FSM, rate buffer register, index + remaining counters,
//    indexed part-select for out_data.
// TESTING (bench drives state_in/perm_valid directly; P0: lane i = i*64'h0101010101010101,
//  P1: lane i = ~P0 lane i)
//  1. start, len=3, P0, out_ready=1 -> words 0, 0101010101010101, 0202020202020202 on
//     consecutive cycles; done 1 cycle after third accept; perm_next never asserted.
//  2. len=21, P0 -> 21 words, last = 1414141414141414; done; no perm_next.
//  3. len=22 -> after word 20, perm_next pulses once; drive P1 -> word 21 =
//     FFFFFFFFFFFFFFFF; done.
//  4. Backpressure: len=5, out_ready toggling 1010.. -> out_data stable while stalled,
//     exact sequence 0,0101..,0202..,0303..,0404..; no drops or duplicates.
//  5. rst asserted after word 2 accepted -> next cycle out_valid=0, busy=0; new start
//     len=1 yields word 0 of freshly captured state.
//  6. start len=0 -> done next cycle, busy stays 0; start while busy -> ignored.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants and the squeeze reader state encoding.
//   STATE_W        : width of the full Keccak-f[1600] state
//   LANE_W         : width of one Keccak lane
//   SHAKE128_RATE  : SHAKE128 rate in bits
//   SHAKE256_RATE  : SHAKE256 rate in bits
//   squeeze_state_t: IDLE / WAIT (for permutation) / STREAM (words out)
package keccak_pkg;

    localparam int STATE_W       = 1600;
    localparam int LANE_W        = 64;
    localparam int SHAKE128_RATE = 1344;
    localparam int SHAKE256_RATE = 1088;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } squeeze_state_t;

endpackage

// File: rtl/shake_squeeze_reader.sv
// Squeeze-side reader for the Keccak permutation. Captures the rate part of
// the state when the permutation reports valid, streams it out one word per
// accepted handshake, and asks the permutation for another block whenever the
// rate is exhausted before len_words words have been delivered.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   start       : one-cycle request, honoured only in IDLE
//   len_words   : number of words to deliver, sampled with start
//   perm_valid  : state_in holds a valid permuted state
//   state_in    : full 1600-bit permutation state (lane-little-endian)
//   perm_next   : one-cycle pulse asking the permutation to run again
//   out_data    : current output word
//   out_valid   : out_data is valid; held until accepted
//   out_ready   : consumer accepts out_data when out_valid & out_ready
//   busy        : high whenever the reader is not IDLE
//   done        : one-cycle pulse after the last word is accepted
module shake_squeeze_reader
    import keccak_pkg::*;
#(
    parameter int RATE_BITS = SHAKE128_RATE,
    parameter int WORD_W    = LANE_W,
    parameter int LEN_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len_words,
    input  logic               perm_valid,
    input  logic [STATE_W-1:0] state_in,
    output logic               perm_next,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done
);

    localparam int WORDS = RATE_BITS / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    squeeze_state_t                 state_r;
    logic [WORDS-1:0][WORD_W-1:0]   buf_r;
    logic [IDX_W-1:0]               idx_r;
    logic [LEN_W-1:0]               rem_r;

    logic                           accept_s;
    logic                           last_s;
    logic                           wrap_s;
    logic [IDX_W-1:0]               idx_inc_s;
    logic                           capacity_unused_s;

    assign accept_s  = out_valid & out_ready;
    assign last_s    = (rem_r == LEN_W'(1));
    assign wrap_s    = (idx_r == IDX_W'(WORDS - 1));
    assign idx_inc_s = idx_r + IDX_W'(1);

    // Capacity lanes are deliberately never stored.
    assign capacity_unused_s = ^state_in[STATE_W-1:RATE_BITS];

    // Squeeze FSM: rate buffer capture, word sequencing and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            buf_r     <= '0;
            idx_r     <= IDX_W'(0);
            rem_r     <= LEN_W'(0);
            perm_next <= 1'b0;
            out_data  <= WORD_W'(0);
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Pulse outputs default low; set for exactly one cycle below.
            perm_next <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (len_words == LEN_W'(0)) begin
                            done <= 1'b1;
                        end else begin
                            rem_r   <= len_words;
                            state_r <= WAIT;
                            busy    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (perm_valid) begin
                        buf_r     <= state_in[RATE_BITS-1:0];
                        idx_r     <= IDX_W'(0);
                        // Word 0 comes straight from the input so it is valid next cycle.
                        out_data  <= state_in[WORD_W-1:0];
                        out_valid <= 1'b1;
                        state_r   <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept_s) begin
                        rem_r <= rem_r - LEN_W'(1);
                        if (last_s) begin
                            // Finishing wins over block wrap: no extra permutation.
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            idx_r     <= IDX_W'(0);
                            state_r   <= IDLE;
                        end else if (wrap_s) begin
                            out_valid <= 1'b0;
                            perm_next <= 1'b1;
                            idx_r     <= IDX_W'(0);
                            state_r   <= WAIT;
                        end else begin
                            idx_r    <= idx_inc_s;
                            out_data <= buf_r[idx_inc_s];
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shake_squeeze_reader.sv
// Directed self-checking bench for shake_squeeze_reader (default SHAKE128 geometry).
module tb_shake_squeeze_reader;

    logic          clk;
    logic          rst;
    logic          start;
    logic [15:0]   len_words;
    logic          perm_valid;
    logic [1599:0] state_in;
    logic          perm_next;
    logic [63:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int            checks;
    int            errors;

    logic [1599:0] p0;
    logic [1599:0] p1;

    logic [63:0]   got[$];
    int            push_it[$];
    int            pn_it[$];
    int            done_it;

    shake_squeeze_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len_words  (len_words),
        .perm_valid (perm_valid),
        .state_in   (state_in),
        .perm_next  (perm_next),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected overall word k: blocks of 21 lanes, alternating P0 / P1 starting from blk0.
    function automatic logic [63:0] exp_word(input int k, input bit blk0);
        logic [63:0] lane;
        bit          odd;
        lane = 64'(k % 21) * 64'h0101010101010101;
        odd  = ((k / 21) % 2 == 1) ^ blk0;
        return odd ? ~lane : lane;
    endfunction

    // Runs one squeeze request; the bench plays the permutation and the consumer.
    task automatic do_run(input int len, input bit toggle, input int pv_delay,
                          input bit inject, input bit blk0);
        int          pv_cnt;
        bit          blk;
        bit          prev_stall;
        logic [63:0] prev_data;
        got.delete();
        push_it.delete();
        pn_it.delete();
        done_it    = -1;
        blk        = blk0;
        state_in   = blk ? p1 : p0;
        perm_valid = (pv_delay == 0);
        pv_cnt     = pv_delay;
        out_ready  = 1'b1;
        start      = 1'b1;
        len_words  = 16'(len);
        prev_stall = 1'b0;
        prev_data  = 64'h0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int it = 0; it < 300; it++) begin
            if (perm_next) begin
                pn_it.push_back(it);
                blk        = ~blk;
                perm_valid = 1'b0;
                pv_cnt     = 2;
            end else if (!perm_valid) begin
                pv_cnt--;
                if (pv_cnt <= 0) begin
                    perm_valid = 1'b1;
                    state_in   = blk ? p1 : p0;
                end
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'h1);
                chk("stall_data", out_data, prev_data);
            end
            if (done) begin
                done_it = it;
                break;
            end
            if (inject && it == 1) begin
                chk("inject_busy", 64'(busy), 64'h1);
                start     = 1'b1;
                len_words = 16'd7;
            end else begin
                start = 1'b0;
            end
            out_ready = toggle ? (it % 2 == 0) : 1'b1;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                push_it.push_back(it);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done_seen", 64'(done_it >= 0), 64'h1);
        chk("word_count", 64'(got.size()), 64'(len));
        for (int k = 0; k < got.size(); k++) begin
            chk($sformatf("word%0d", k), got[k], exp_word(k, blk0));
        end
        if (push_it.size() > 0) begin
            chk("done_latency", 64'(done_it), 64'(push_it[push_it.size()-1] + 1));
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        len_words  = 16'd0;
        perm_valid = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 25; i++) begin
            p0[i*64 +: 64] = 64'(i) * 64'h0101010101010101;
        end
        p1       = ~p0;
        state_in = p0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_perm_next", 64'(perm_next), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1. Three words from one block, full throughput
        do_run(3, 1'b0, 0, 1'b0, 1'b0);
        chk("t1_word2", got[2], 64'h0202020202020202);
        chk("t1_no_perm_next", 64'(pn_it.size()), 64'h0);
        chk("t1_back_to_back", 64'(push_it[2] - push_it[0]), 64'd2);
        chk("t1_idle_busy", 64'(busy), 64'h0);

        // 2. Exactly one full block
        do_run(21, 1'b0, 0, 1'b0, 1'b0);
        chk("t2_last", got[20], 64'h1414141414141414);
        chk("t2_no_perm_next", 64'(pn_it.size()), 64'h0);
        chk("t2_back_to_back", 64'(push_it[20] - push_it[0]), 64'd20);

        // 3. One word past the block: one perm_next, then P1 lane 0
        do_run(22, 1'b0, 0, 1'b0, 1'b0);
        chk("t3_perm_next_count", 64'(pn_it.size()), 64'h1);
        chk("t3_perm_next_time", 64'(pn_it[0]), 64'(push_it[20] + 1));
        chk("t3_word21", got[21], 64'hFFFFFFFFFFFFFFFF);

        // 4. Backpressure with out_ready toggling
        do_run(5, 1'b1, 0, 1'b0, 1'b0);
        chk("t4_word4", got[4], 64'h0404040404040404);

        // 5. Reset in the middle of a stream
        state_in   = p0;
        perm_valid = 1'b1;
        out_ready  = 1'b1;
        start      = 1'b1;
        len_words  = 16'd10;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int n_acc;
            n_acc = 0;
            for (int it = 0; it < 20 && n_acc < 3; it++) begin
                if (out_valid) n_acc++;
                @(posedge clk); #1;
            end
            chk("t5_three_accepted", 64'(n_acc), 64'd3);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_out_valid", 64'(out_valid), 64'h0);
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_out_data", out_data, 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        do_run(1, 1'b0, 0, 1'b0, 1'b1);
        chk("t5_fresh_word0", got[0], 64'hFFFFFFFFFFFFFFFF);

        // 6. Zero-length request, then start ignored while busy
        perm_valid = 1'b0;
        start      = 1'b1;
        len_words  = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t6_done", 64'(done), 64'h1);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_perm_next", 64'(perm_next), 64'h0);
        @(posedge clk); #1;
        chk("t6_done_pulse", 64'(done), 64'h0);
        chk("t6_still_idle", 64'(busy), 64'h0);
        do_run(2, 1'b0, 3, 1'b1, 1'b0);
        chk("t6_no_perm_next", 64'(pn_it.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
